// File: rtl/grey_pkg.sv
// Shared definitions for the Gray-to-binary stream decoder and its step checker.
// grey2bin() is the reference decode, usable by the design and by golden models.
package grey_pkg;

    typedef enum logic {
        NO_REF = 1'b0,
        TRACK  = 1'b1
    } chk_state_e;

    localparam int GREY_MAX_W = 32;

    // Bit i of the result is the XOR of all Gray bits at or above i, within width.
    function automatic logic [GREY_MAX_W-1:0] grey2bin(input logic [GREY_MAX_W-1:0] g,
                                                       input int width);
        logic [GREY_MAX_W-1:0] b;
        logic                  acc;
        b   = '0;
        acc = 1'b0;
        for (int i = GREY_MAX_W - 1; i >= 0; i--) begin
            if (i < width) begin
                acc  = acc ^ g[i];
                b[i] = acc;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/grey_step_checker.sv
// Tracks the previous accepted Gray word and flags transitions of two or more bits.
// Latency: step_bad is combinational on the accepting word; err_count updates on that edge.
// Backpressure: none of its own; state advances only on the top's accept strobe.
module grey_step_checker
    import grey_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             accept,
    input  logic [WIDTH-1:0] g,
    output logic             step_bad,
    output logic [CNT_W-1:0] err_count
);

    localparam int PW = $clog2(WIDTH + 1);

    chk_state_e       state_q, state_d;
    logic [WIDTH-1:0] prev_g_q, prev_g_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [WIDTH-1:0] diff;
    logic [PW-1:0]    ones;

    always_comb begin
        diff = g ^ prev_g_q;
        ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + PW'(diff[i]);
        end
        // The very first word after reset has nothing to be compared against.
        step_bad = (state_q == TRACK) && (ones > PW'(1));

        state_d     = state_q;
        prev_g_d    = prev_g_q;
        err_count_d = err_count_q;
        if (accept) begin
            state_d  = TRACK;
            prev_g_d = g;
            if (step_bad && (err_count_q != {CNT_W{1'b1}})) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= NO_REF;
            prev_g_q    <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            prev_g_q    <= prev_g_d;
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;

endmodule

// File: rtl/grey_to_bin_stream.sv
// Streaming Gray-to-binary decoder, 1 cycle latency, 1-deep output register (1 word/clk).
// Stalls input (in_ready=0) only while a held word is not taken; GREY_STEP_CHECK_EN adds the step checker.
module grey_to_bin_stream
    import grey_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] g,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b,
    output logic             step_err,
    output logic [CNT_W-1:0] err_count
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             step_err_q, step_err_d;
    logic [WIDTH-1:0] b_dec;
    logic             accept;
    logic             step_bad;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        b_dec = '0;
        b_dec[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b_dec[i] = b_dec[i+1] ^ g[i];
        end

        out_valid_d = out_valid_q;
        b_d         = b_q;
        step_err_d  = step_err_q;
        if (accept) begin
            out_valid_d = 1'b1;
            b_d         = b_dec;
            step_err_d  = step_bad;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            b_q         <= '0;
            step_err_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            b_q         <= b_d;
            step_err_q  <= step_err_d;
        end
    end

`ifdef GREY_STEP_CHECK_EN
    grey_step_checker #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step_checker (
        .clk       (clk),
        .rst_n     (rst_n),
        .accept    (accept),
        .g         (g),
        .step_bad  (step_bad),
        .err_count (err_count)
    );
`else
    assign step_bad  = 1'b0;
    assign err_count = '0;
`endif

    assign out_valid = out_valid_q;
    assign b         = b_q;
    assign step_err  = step_err_q;

endmodule

// File: tb/tb_grey_to_bin_stream.sv
// Directed bench for grey_to_bin_stream (WIDTH=4, CNT_W=8); step_err/err_count
// expectations follow whether GREY_STEP_CHECK_EN is defined in this build.
module tb_grey_to_bin_stream;

`ifdef GREY_STEP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] g;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] b;
    logic       step_err;
    logic [7:0] err_count;

    int         n_tests;
    int         n_fail;
    logic [7:0] exp_cnt;

    grey_to_bin_stream #(
        .WIDTH (4),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .g         (g),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .b         (b),
        .step_err  (step_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one word for exactly one rising edge, then sample 1 time unit later.
    task automatic drive_word(input logic [3:0] gv);
        in_valid = 1'b1;
        g        = gv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic bump_expected(input logic bad);
        if (CHK && bad && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        g         = 4'b0000;
        exp_cnt   = 8'd0;
        #23;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_tests++; if (b !== 4'd0) begin n_fail++; $display("FAIL reset_b got=%h exp=0", b); end
        n_tests++; if (step_err !== 1'b0) begin n_fail++; $display("FAIL reset_step_err got=%b exp=0", step_err); end
        n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_sweep();
        logic [3:0] gv;
        logic [3:0] iv;
        for (int i = 0; i < 16; i++) begin
            iv = 4'(i);
            gv = iv ^ (iv >> 1);
            drive_word(gv);
            n_tests++; if (out_valid !== 1'b1 || b !== iv) begin n_fail++; $display("FAIL sweep_b g=%b got_vld=%b got_b=%b exp_b=%b", gv, out_valid, b, iv); end
            n_tests++; if (step_err !== 1'b0) begin n_fail++; $display("FAIL sweep_step_err g=%b got=%b exp=0", gv, step_err); end
        end
        n_tests++; if (err_count !== exp_cnt) begin n_fail++; $display("FAIL sweep_err_count got=%0d exp=%0d", err_count, exp_cnt); end
        @(posedge clk); #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sweep_drain got_vld=%b exp=0", out_valid); end
    endtask

    task automatic test_illegal_step();
        logic [3:0] gs  [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0000};
        logic [3:0] bs  [4] = '{4'b0000, 4'b0001, 4'b0010, 4'b0000};
        logic       bad [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive_word(gs[i]);
            bump_expected(bad[i]);
            n_tests++; if (out_valid !== 1'b1 || b !== bs[i]) begin n_fail++; $display("FAIL illegal_b idx=%0d got_vld=%b got_b=%b exp_b=%b", i, out_valid, b, bs[i]); end
            n_tests++; if (step_err !== (CHK & bad[i])) begin n_fail++; $display("FAIL illegal_step_err idx=%0d got=%b exp=%b", i, step_err, CHK & bad[i]); end
            n_tests++; if (err_count !== exp_cnt) begin n_fail++; $display("FAIL illegal_err_count idx=%0d got=%0d exp=%0d", i, err_count, exp_cnt); end
        end
    endtask

    task automatic test_wrap_repeat();
        logic [3:0] gs [3] = '{4'b1000, 4'b0000, 4'b0000};
        logic [3:0] bs [3] = '{4'b1111, 4'b0000, 4'b0000};
        for (int i = 0; i < 3; i++) begin
            drive_word(gs[i]);
            n_tests++; if (out_valid !== 1'b1 || b !== bs[i]) begin n_fail++; $display("FAIL wrap_b idx=%0d got_vld=%b got_b=%b exp_b=%b", i, out_valid, b, bs[i]); end
            n_tests++; if (step_err !== 1'b0) begin n_fail++; $display("FAIL wrap_step_err idx=%0d got=%b exp=0", i, step_err); end
            n_tests++; if (err_count !== exp_cnt) begin n_fail++; $display("FAIL wrap_err_count idx=%0d got=%0d exp=%0d", i, err_count, exp_cnt); end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        drive_word(4'b0001);
        n_tests++; if (out_valid !== 1'b1 || b !== 4'd1) begin n_fail++; $display("FAIL bp_first got_vld=%b got_b=%b exp_b=0001", out_valid, b); end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        g         = 4'b0011;
        #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_tests++; if (out_valid !== 1'b1 || b !== 4'd1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold cyc=%0d got_vld=%b got_b=%b got_rdy=%b exp=1/0001/0", i, out_valid, b, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_rdy got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || b !== 4'd2 || step_err !== 1'b0) begin n_fail++; $display("FAIL bp_second got_vld=%b got_b=%b got_err=%b exp=1/0010/0", out_valid, b, step_err); end
        @(posedge clk); #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got_vld=%b exp=0", out_valid); end
    endtask

    task automatic test_mid_reset();
        drive_word(4'b0010);
        out_ready = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || b !== 4'd3) begin n_fail++; $display("FAIL mrst_pre got_vld=%b got_b=%b exp=1/0011", out_valid, b); end
        #2 rst_n = 1'b0;
        #1;
        exp_cnt = 8'd0;
        n_tests++; if (out_valid !== 1'b0 || b !== 4'd0 || step_err !== 1'b0) begin n_fail++; $display("FAIL mrst_clear got_vld=%b got_b=%b got_err=%b exp=0/0000/0", out_valid, b, step_err); end
        n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL mrst_err_count got=%0d exp=0", err_count); end
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        drive_word(4'b1111);
        n_tests++; if (out_valid !== 1'b1 || b !== 4'b1010 || step_err !== 1'b0) begin n_fail++; $display("FAIL mrst_first got_vld=%b got_b=%b got_err=%b exp=1/1010/0", out_valid, b, step_err); end
        drive_word(4'b0000);
        bump_expected(1'b1);
        n_tests++; if (b !== 4'd0 || step_err !== CHK) begin n_fail++; $display("FAIL mrst_second got_b=%b got_err=%b exp=0000/%b", b, step_err, CHK); end
        n_tests++; if (err_count !== exp_cnt) begin n_fail++; $display("FAIL mrst_second_cnt got=%0d exp=%0d", err_count, exp_cnt); end
    endtask

    task automatic test_saturate();
        logic [3:0] gv;
        logic [3:0] bv;
        for (int k = 0; k < 260; k++) begin
            gv = (k % 2 == 0) ? 4'b0011 : 4'b0000;
            bv = (k % 2 == 0) ? 4'b0010 : 4'b0000;
            drive_word(gv);
            bump_expected(1'b1);
            n_tests++; if (b !== bv || step_err !== CHK) begin n_fail++; $display("FAIL sat_word k=%0d got_b=%b got_err=%b exp=%b/%b", k, b, step_err, bv, CHK); end
            n_tests++; if (err_count !== exp_cnt) begin n_fail++; $display("FAIL sat_count k=%0d got=%0d exp=%0d", k, err_count, exp_cnt); end
        end
        n_tests++; if (err_count !== (CHK ? 8'hFF : 8'h00)) begin n_fail++; $display("FAIL sat_final got=%0d exp=%0d", err_count, CHK ? 255 : 0); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_sweep();
        test_illegal_step();
        test_wrap_repeat();
        test_backpressure();
        test_mid_reset();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
